// File: rtl/flash_pkg.sv
// Shared sizing and FSM state encoding for the word loader.
package flash_pkg;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ERASE = 2'd2
    } state_t;

    // Step the read pointer through the stored words only, wrapping at count.
    // An empty memory pins the pointer at 0.
    function automatic logic [AW-1:0] next_rd_ptr(input logic [AW-1:0] rd,
                                                  input logic [CW-1:0] cnt);
        logic [CW-1:0] inc;
        inc = {1'b0, rd} + CW'(1);
        if (cnt == '0 || inc == cnt) begin
            return '0;
        end
        return inc[AW-1:0];
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Turns a raw button level into a single-cycle pulse on its rising edge.
module edge_pulse (
    input  logic clk,
    input  logic nRST,
    input  logic raw_in,
    output logic pulse
);

    logic q1_q, q1_d;
    logic q2_q, q2_d;

    // Two-stage sample chain; q2 is q1 delayed by one cycle.
    always_comb begin
        q1_d = raw_in;
        q2_d = q1_q;
    end

    // Sample chain registers, cleared asynchronously.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    // Pulse is high for the first cycle the sampled level is seen high.
    assign pulse = q1_q && !q2_q;

endmodule

// File: rtl/word_loader.sv
// Collects toggle-bank words into an 8-deep memory with load, step-read and
// erase-all buttons. Every load (accepted or not) clears the toggle bank.
module word_loader
    import flash_pkg::*;
(
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_btn,
    input  logic             read_btn,
    input  logic             erase_btn,
    output logic             clear,
    output logic [WIDTH-1:0] word_out,
    output logic [AW-1:0]    rd_addr,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow,
    output logic             busy
);

    logic load_pulse;
    logic read_pulse;
    logic erase_pulse;

    edge_pulse u_load_edge  (.clk(clk), .nRST(nRST), .raw_in(load_btn),  .pulse(load_pulse));
    edge_pulse u_read_edge  (.clk(clk), .nRST(nRST), .raw_in(read_btn),  .pulse(read_pulse));
    edge_pulse u_erase_edge (.clk(clk), .nRST(nRST), .raw_in(erase_btn), .pulse(erase_pulse));

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      erase_idx_q, erase_idx_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;

    // FSM state register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: erase outranks load; pulses outside IDLE are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (erase_pulse) begin
                    state_d = ST_ERASE;
                end else if (load_pulse) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            ST_ERASE: begin
                if (erase_idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        clear = (state_q == ST_CLEAR);
        busy  = (state_q != ST_IDLE);
    end

    // Datapath next values: memory writes, pointer moves, erase sweep.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        erase_idx_d = erase_idx_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (erase_pulse) begin
                    erase_idx_d = '0;
                end else if (load_pulse) begin
                    if (count_q < CW'(DEPTH)) begin
                        mem_d[wr_ptr_q] = data_in;
                        wr_ptr_d        = wr_ptr_q + AW'(1);
                        count_d         = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (read_pulse) begin
                    rd_ptr_d = next_rd_ptr(rd_ptr_q, count_q);
                end
            end
            ST_ERASE: begin
                mem_d[erase_idx_q] = '0;
                erase_idx_d        = erase_idx_q + AW'(1);
                if (erase_idx_q == AW'(DEPTH - 1)) begin
                    count_d    = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset wipes memory and pointers immediately.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            erase_idx_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            erase_idx_q <= erase_idx_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Status outputs.
    always_comb begin
        word_out = mem_q[rd_ptr_q];
        rd_addr  = rd_ptr_q;
        count    = count_q;
        full     = (count_q == CW'(DEPTH));
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_word_loader.sv
// Directed bench for word_loader: load, overflow, read stepping, erase,
// simultaneous load/erase and reset during an erase sweep.
module tb_word_loader;

    logic        clk = 1'b0;
    logic        nRST;
    logic [15:0] data_in;
    logic        load_btn, read_btn, erase_btn;
    logic        clear;
    logic [15:0] word_out;
    logic [2:0]  rd_addr;
    logic [3:0]  count;
    logic        full, overflow, busy;

    int checks = 0;
    int errors = 0;

    word_loader dut (
        .clk(clk), .nRST(nRST), .data_in(data_in),
        .load_btn(load_btn), .read_btn(read_btn), .erase_btn(erase_btn),
        .clear(clear), .word_out(word_out), .rd_addr(rd_addr), .count(count),
        .full(full), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        nRST = 1'b0; load_btn = 1'b0; read_btn = 1'b0; erase_btn = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
    endtask

    // Press and release Load; reports clear one and two cycles after the action edge.
    task automatic load_word(input logic [15:0] d, output logic clr1, output logic clr2);
        data_in = d; load_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr1 = clear;
        load_btn = 1'b0;
        @(negedge clk);
        clr2 = clear;
        @(negedge clk);
    endtask

    task automatic read_step();
        read_btn = 1'b1;
        repeat (2) @(negedge clk);
        read_btn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Press Erase and count busy cycles; bounded so a stuck FSM cannot hang.
    task automatic erase_run(output int busy_cycles);
        erase_btn = 1'b1;
        @(negedge clk);
        erase_btn = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            else if (busy_cycles > 0) break;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; load_btn = 1'b0; read_btn = 1'b0; erase_btn = 1'b0; data_in = 16'hFFFF;
        #1;
        checks++; if ({clear, busy, full, overflow} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {clear, busy, full, overflow}); end
        checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL reset_word: got %h expected 0000", word_out); end
        checks++; if ({rd_addr, count} !== 7'd0) begin errors++; $display("FAIL reset_addr_count: got %0d/%0d expected 0/0", rd_addr, count); end
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({clear, busy, count} !== 6'd0) begin errors++; $display("FAIL post_reset: got clear %b busy %b count %0d expected 0 0 0", clear, busy, count); end
    endtask

    task automatic test_single_load();
        logic c1, c2;
        do_reset();
        load_word(16'hA5A5, c1, c2);
        checks++; if ({c1, c2} !== 2'b10) begin errors++; $display("FAIL single_clear_pulse: got %b expected 10", {c1, c2}); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL single_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (word_out !== 16'hA5A5) begin errors++; $display("FAIL single_word: got %h expected a5a5", word_out); end
        checks++; if ({busy, full, overflow} !== 3'b000) begin errors++; $display("FAIL single_flags: got %b expected 000", {busy, full, overflow}); end
    endtask

    task automatic test_overflow();
        logic c1, c2;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            load_word(16'(i), c1, c2);
        end
        checks++; if ({full, overflow, count} !== {2'b10, 4'd8}) begin errors++; $display("FAIL ovf_after8: got full %b ovf %b count %0d expected 1 0 8", full, overflow, count); end
        load_word(16'h0009, c1, c2);
        checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL ovf_clear: got %b expected 1", c1); end
        checks++; if ({full, overflow, count} !== {2'b11, 4'd8}) begin errors++; $display("FAIL ovf_after9: got full %b ovf %b count %0d expected 1 1 8", full, overflow, count); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (rd_addr !== 3'(k) || word_out !== 16'(k + 1)) begin errors++; $display("FAIL ovf_mem_%0d: got addr %0d word %h expected %0d %h", k, rd_addr, word_out, k, 16'(k + 1)); end
            read_step();
        end
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL ovf_rd_wrap: got %0d expected 0", rd_addr); end
    endtask

    task automatic test_read();
        logic c1, c2;
        logic [2:0]  exp_a [4];
        logic [15:0] exp_w [4];
        exp_a[0] = 3'd1; exp_a[1] = 3'd2; exp_a[2] = 3'd0; exp_a[3] = 3'd1;
        exp_w[0] = 16'h2222; exp_w[1] = 16'h3333; exp_w[2] = 16'h1111; exp_w[3] = 16'h2222;
        do_reset();
        read_step();
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL read_empty: got %0d expected 0", rd_addr); end
        load_word(16'h1111, c1, c2);
        load_word(16'h2222, c1, c2);
        load_word(16'h3333, c1, c2);
        for (int k = 0; k < 4; k++) begin
            read_step();
            checks++; if (rd_addr !== exp_a[k] || word_out !== exp_w[k]) begin errors++; $display("FAIL read_step_%0d: got addr %0d word %h expected %0d %h", k, rd_addr, word_out, exp_a[k], exp_w[k]); end
        end
    endtask

    task automatic test_erase();
        logic c1, c2;
        int n;
        do_reset();
        load_word(16'h0A0A, c1, c2);
        load_word(16'h0B0B, c1, c2);
        load_word(16'h0C0C, c1, c2);
        load_word(16'h0D0D, c1, c2);
        read_step();
        erase_run(n);
        checks++; if (n != 8) begin errors++; $display("FAIL erase_busy_cycles: got %0d expected 8", n); end
        checks++; if ({count, rd_addr, overflow, full} !== 9'd0) begin errors++; $display("FAIL erase_state: got count %0d addr %0d ovf %b full %b expected 0 0 0 0", count, rd_addr, overflow, full); end
        checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL erase_word: got %h expected 0000", word_out); end
        load_word(16'h1234, c1, c2);
        read_step();
        checks++; if (count !== 4'd1 || rd_addr !== 3'd0 || word_out !== 16'h1234) begin errors++; $display("FAIL erase_reload: got count %0d addr %0d word %h expected 1 0 1234", count, rd_addr, word_out); end
        for (int i = 0; i < 8; i++) begin
            load_word(16'h5000 + 16'(i), c1, c2);
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL erase_pre_ovf: got %b expected 1", overflow); end
        erase_run(n);
        checks++; if ({overflow, full, count} !== 6'd0 || word_out !== 16'h0000) begin errors++; $display("FAIL erase_clears_ovf: got ovf %b full %b count %0d word %h expected 0 0 0 0000", overflow, full, count, word_out); end
    endtask

    task automatic test_load_erase_same();
        logic c1, c2;
        logic clear_seen;
        int n;
        do_reset();
        load_word(16'h7777, c1, c2);
        load_word(16'h8888, c1, c2);
        data_in = 16'hFFFF; load_btn = 1'b1; erase_btn = 1'b1;
        @(negedge clk);
        erase_btn = 1'b0;
        clear_seen = 1'b0; n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clear) clear_seen = 1'b1;
            if (busy) n++;
        end
        checks++; if (clear_seen !== 1'b0) begin errors++; $display("FAIL same_no_clear: got %b expected 0", clear_seen); end
        checks++; if (n != 8) begin errors++; $display("FAIL same_busy_cycles: got %0d expected 8", n); end
        checks++; if (count !== 4'd0 || word_out !== 16'h0000) begin errors++; $display("FAIL same_erased: got count %0d word %h expected 0 0000", count, word_out); end
        load_btn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL same_release: got count %0d expected 0", count); end
    endtask

    task automatic test_reset_mid_erase();
        logic c1, c2;
        do_reset();
        load_word(16'h1111, c1, c2);
        load_word(16'h2222, c1, c2);
        load_word(16'h3333, c1, c2);
        load_word(16'h4444, c1, c2);
        erase_btn = 1'b1;
        @(negedge clk);
        erase_btn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_erase_busy: got %b expected 1", busy); end
        #1 nRST = 1'b0;
        #1;
        checks++; if ({clear, busy, full, overflow, count, rd_addr} !== 11'd0 || word_out !== 16'h0000) begin errors++; $display("FAIL mid_erase_reset: got clr %b busy %b full %b ovf %b count %0d addr %0d word %h expected all 0", clear, busy, full, overflow, count, rd_addr, word_out); end
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_erase_idle: got busy %b expected 0", busy); end
        load_word(16'hBEEF, c1, c2);
        checks++; if (count !== 4'd1 || rd_addr !== 3'd0 || word_out !== 16'hBEEF) begin errors++; $display("FAIL mid_erase_reload: got count %0d addr %0d word %h expected 1 0 beef", count, rd_addr, word_out); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_overflow();
        test_read();
        test_erase();
        test_load_erase_same();
        test_reset_mid_erase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_loader.md
WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 SHALL have port: clk  input  1  manual clock; all state updates on rising edge.
REQ-002 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: data_in  input  16  stored toggle word from the toggle bank.
REQ-004 SHALL have port: load_btn  input  1  raw Load button.
REQ-005 SHALL have port: read_btn  input  1  raw Read/step button.
REQ-006 SHALL have port: erase_btn  input  1  raw Erase-all button.
REQ-007 SHALL have port: clear  output  1  sync clear to toggle bank, one-cycle pulse.
REQ-008 SHALL have port: word_out  output  16  memory word at read pointer.
REQ-009 SHALL have port: rd_addr  output  3  current read pointer.
REQ-010 SHALL have port: count  output  4  number of stored words, 0..8.
REQ-011 SHALL have port: full  output  1  high when count == 8.
REQ-012 SHALL have port: overflow  output  1  sticky: Load attempted while full.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL hold an 8-entry x 16-bit word memory, write pointer wr_ptr (3 bit) and read pointer rd_ptr (3 bit).
REQ-015 SHALL derive a one-cycle pulse per button: two-flop sample chain q1/q2; pulse = q1 && !q2.
REQ-016 SHALL implement FSM states IDLE, CLEAR, ERASE.
REQ-017 SHALL, in IDLE with load pulse and count < 8: write data_in to mem[wr_ptr], wr_ptr+1 (wraps 7->0), count+1, go to CLEAR, at the same edge.
REQ-018 SHALL, in IDLE with load pulse and count == 8: leave memory/pointers unchanged, set overflow, go to CLEAR (toggle bank still cleared).
REQ-019 SHALL assert clear exactly while state == CLEAR (one cycle); CLEAR always returns to IDLE next edge.
REQ-020 SHALL, in IDLE with read pulse and count > 0: rd_ptr+1, wrapping to 0 when rd_ptr+1 == count; with count == 0, rd_ptr stays 0.
REQ-021 SHALL, in IDLE with erase pulse: go to ERASE with erase index 0; each ERASE cycle writes 0 to mem[index] and increments index; after index 7 is written, go to IDLE with count, wr_ptr, rd_ptr, overflow = 0 (8 cycles in ERASE).
REQ-022 SHALL prioritise simultaneous IDLE pulses erase > load > read; lower-priority pulses in that cycle are dropped.
REQ-023 SHALL drop every button pulse arriving while state is CLEAR or ERASE (no queueing).
REQ-024 SHALL drive word_out = mem[rd_ptr] combinationally; a write to mem[rd_ptr] is visible the cycle after the write edge.
REQ-025 SHALL keep full = (count == 8) combinational; count never exceeds 8.

Reset
REQ-026 SHALL, on nRST low, immediately force state IDLE, all memory words 0, wr_ptr/rd_ptr/erase index/count 0, overflow 0, all edge-detect flops 0.
REQ-027 SHALL therefore present clear 0, busy 0, full 0, word_out 0x0000, rd_addr 0, count 0 during and after reset.
REQ-028 SHALL abort any CLEAR or ERASE sequence when reset asserts mid-operation; no partial state survives.

Structure
REQ-029 SHALL take DEPTH = 8, WIDTH = 16 and the FSM state enum from shared package flash_pkg.
REQ-030 SHALL instantiate sub-module edge_pulse (clk, nRST, raw in, pulse out) once per button (three instances).

Verification
REQ-031 Reset, data_in 0xA5A5, one Load press -> clear high one cycle, count 1, rd_addr 0, word_out 0xA5A5.
REQ-032 Nine Loads of 0x0001..0x0009 -> after eighth full 1, count 8; ninth leaves mem unchanged, overflow 1, clear still pulses.
REQ-033 Three words loaded (0x1111, 0x2222, 0x3333), four Read presses -> rd_addr 1,2,0,1; word_out 0x2222, 0x3333, 0x1111, 0x2222.
REQ-034 Four words loaded, Erase press -> busy high 8 cycles, then count 0, overflow 0, word_out 0x0000 for every rd_addr.
REQ-035 Load and Erase pulses on the same cycle -> Erase wins, no write, no clear pulse; Load held high without release produces no second pulse.
REQ-036 nRST asserted in ERASE cycle 3 -> all outputs at reset values immediately; after release a Load of 0xBEEF stores at address 0, count 1.
